aes_encipher_stream: RTL and testbench
======================================

# aes_encipher_stream

Iterative AES block encipher with per-request key length (128/192/256), an input FIFO, a valid/ready stream on both sides, and a request tag carried through. It sits between the host DMA stream and the key-schedule store. It requests one round key per cycle by index and retires one 128-bit block every Nr+2 cycles when unstalled. The S-box comes from the shared `constant.sbox` table. Round math is the standard FIPS-197 SubBytes, ShiftRows, MixColumns and AddRoundKey, in big-endian byte order (byte 0 = bits [127:120]).

## Interface
- `IN_FIFO_DEPTH`, default 2: input buffer entries; must be a power of 2 and ≥ 2.
- `ID_W`, default 4: width of the request tag carried from input to output.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: request valid.
- `in_ready` output 1: the FIFO is not full.
- `in_block` input 128: plaintext.
- `in_keylen` input 2: key length select. 00 = AES-128 (Nr=10), 01 = AES-192 (Nr=12), 10 = AES-256 (Nr=14), 11 = illegal.
- `in_id` input ID_W: request tag.
- `key_round` output 4: index of the round key required this cycle.
- `key_len` output 2: keylen of the block in flight.
- `round_key` input 128: key for `key_round`/`key_len`. Combinational; valid in the same cycle.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_block` output 128: ciphertext.
- `out_id` output ID_W: tag of the result.
- `out_err` output 1: the request had keylen 11.
- `busy` output 1: the engine is not in IDLE, or the FIFO is not empty.

## Operation
- Push into the FIFO on `in_valid & in_ready`. An entry holds {id, keylen, block}. `in_ready = !full`. A pop in the same cycle does not free a slot for a push while full.
- FSM states: IDLE, ROUND, LAST, DONE.
- **IDLE**, FIFO not empty:
  - pop the head entry;
  - drive `key_round=0`;
  - `state_reg <= in_block_head ^ round_key`;
  - latch id and keylen;
  - set `rnd <= 1`;
  - go to ROUND.
- **ROUND**:
  - `key_round = rnd`;
  - `state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ round_key`;
  - `rnd <= rnd + 1`;
  - go to LAST when `rnd == Nr-1`.
- **LAST**:
  - `key_round = Nr`;
  - `out_block <= ShiftRows(SubBytes(state_reg)) ^ round_key`;
  - `out_valid <= 1`, and `out_id` and `out_err` are loaded;
  - go to DONE.
- **DONE**: hold all outputs stable. On `out_ready`: `out_valid <= 0`, go to IDLE. The FIFO keeps accepting input throughout.
- Keylen 11 is processed as AES-128 (Nr=10, `key_len` driven 00) with `out_err=1`. It is never dropped.
- Outside IDLE-with-pop, ROUND and LAST, `key_round` = 0 and `key_len` = the last latched value.
- `rnd` is 4 bits. Max Nr=14, so it never wraps.

## Timing
- Reset values:
  - `in_ready=1`, `out_valid=0`, `out_block=0`, `out_id=0`, `out_err=0`;
  - `key_round=0`, `key_len=0`, `busy=0`;
  - FIFO empty, FSM IDLE.
- Latency: a push at edge E0 into an empty FIFO with the engine idle gives `out_valid` high after edge E0+Nr+1. That is 11, 13 or 15 cycles.
- Throughput: one block per Nr+2 cycles when `out_ready` is held high (DONE takes one cycle).
- `out_valid` stays high until it is accepted. `out_block`, `out_id` and `out_err` do not change while `out_valid & !out_ready`.
- Reset mid-operation clears the in-flight block, the FIFO contents and the outputs immediately. No partial result is emitted.

## Configuration
- `AES_CBC_EN` defined adds these ports:
  - `in_chain` input 1, stored per FIFO entry;
  - `iv_load` input 1;
  - `iv` input 128.
- It also adds a 128-bit chain register, reset to 0:
  - `iv_load` writes `iv` into the chain register. It is honoured only in IDLE with no pop that cycle; otherwise it is ignored.
  - When the popped entry has `in_chain=1`, round 0 uses `in_block ^ chain ^ round_key`.
  - Every non-error result loads `out_block` into the chain register on the LAST edge.
- `AES_CBC_EN` undefined: these ports and the chain register are absent, and operation is pure ECB.

## Test plan
- **AES-128 FIPS-197 vector:**
  - key 000102…0f, plaintext 00112233445566778899aabbccddeeff, `out_ready=1`;
  - require `out_block=69c4e0d86a7b0430d8cdb78070b4c55a` with `out_valid` high exactly 11 cycles after the push.
- **AES-192 and AES-256 vectors:**
  - key 00…17 gives dda97ca4864cdfe06eaf70a0ec0d7191 at 13 cycles;
  - key 00…1f gives 8ea2b7ca516745bfeafc49904b496089 at 15 cycles;
  - `key_len` matches the request.
- **Backpressure:**
  - push 4 blocks (ids 1–4) with depth 2 and `out_ready=0`;
  - require `in_ready=0` after the FIFO fills;
  - result id 1 is held stable;
  - releasing `out_ready` yields ids 1, 2, 3, 4 in order with correct ciphertext.
- **Illegal keylen:**
  - `in_keylen=11`, id 7;
  - require `out_err=1`, `out_id=7`, ciphertext equal to the AES-128 result, and `key_len=00` during processing.
- **Mid-operation reset:**
  - assert `rst_n=0` during round 5;
  - require all outputs at their reset values and the FIFO empty;
  - the next request produces the correct result.
- **CBC (with `AES_CBC_EN` defined):**
  - `iv_load` with iv 000102…0f, then two `in_chain=1` blocks;
  - require the outputs to match the NIST SP800-38A CBC-AES128 vectors 7649abac8119b246cee98e9b12e9197d and 5086cb9b507219ee95db113a917678b2.

Source files
------------

// File: rtl/aes_encipher_stream.sv
// aes_encipher_stream: iterative AES-128/192/256 encipher behind a small input FIFO,
// one round per cycle with round keys fetched by index. Define AES_CBC_EN for CBC chaining.

module aes_col (
  input  logic [31:0] col,
  output logic [31:0] sub,
  output logic [31:0] mix
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  // Byte x sits at bit offset 8*(255-x) == {~x, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  assign a0  = sbox(col[31:24]);
  assign a1  = sbox(col[23:16]);
  assign a2  = sbox(col[15:8]);
  assign a3  = sbox(col[7:0]);
  assign sub = {a0, a1, a2, a3};
  assign mix = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
endmodule

module aes_encipher_stream #(
  parameter int IN_FIFO_DEPTH = 2,
  parameter int ID_W          = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    in_block,
  input  logic [1:0]      in_keylen,
  input  logic [ID_W-1:0] in_id,
`ifdef AES_CBC_EN
  input  logic            in_chain,
  input  logic            iv_load,
  input  logic [127:0]    iv,
`endif
  output logic [3:0]      key_round,
  output logic [1:0]      key_len,
  input  logic [127:0]    round_key,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_block,
  output logic [ID_W-1:0] out_id,
  output logic            out_err,
  output logic            busy
);
  localparam int AW       = $clog2(IN_FIFO_DEPTH);
  localparam int NUM_COLS = 4;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      keylen;
`ifdef AES_CBC_EN
    logic            chain;
`endif
    logic [127:0]    block;
  } req_t;

  typedef enum logic [1:0] {IDLE, ROUND, LAST, DONE} fsm_t;

  // Input FIFO: extra pointer bit distinguishes full from empty
  req_t        fifo_mem [IN_FIFO_DEPTH];
  req_t        in_req, head;
  logic [AW:0] wptr, rptr;
  logic        full, empty, push, pop;
  fsm_t        fsm;

  assign in_req.id     = in_id;
  assign in_req.keylen = in_keylen;
  assign in_req.block  = in_block;
`ifdef AES_CBC_EN
  assign in_req.chain  = in_chain;
`endif

  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (fsm == IDLE) && !empty;
  assign head     = fifo_mem[rptr[AW-1:0]];
  assign busy     = (fsm != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr[AW-1:0]] <= in_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Round datapath: ShiftRows is pure wiring, so it is applied before SubBytes
  logic [127:0]                st, sub_state, mix_state, round0_in, final_blk;
  logic [NUM_COLS-1:0][31:0]   sr_col, sub_col, mix_col;

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr_col[c][31-8*r -: 8] = st[127-8*(4*((c+r)%NUM_COLS)+r) -: 8];
    end
    aes_col u_col (.col(sr_col[c]), .sub(sub_col[c]), .mix(mix_col[c]));
    assign sub_state[127-32*c -: 32] = sub_col[c];
    assign mix_state[127-32*c -: 32] = mix_col[c];
  end

  logic [3:0]      rnd, nr;
  logic [1:0]      kl_q, head_kl;
  logic [ID_W-1:0] id_q;
  logic            err_q;

  // Illegal keylen runs as AES-128 and is flagged on the result
  assign head_kl   = (head.keylen == 2'b11) ? 2'b00 : head.keylen;
  assign nr        = 4'd10 + {1'b0, kl_q, 1'b0};
  assign final_blk = sub_state ^ round_key;

`ifdef AES_CBC_EN
  logic [127:0] chain_q;
  assign round0_in = head.block ^ (head.chain ? chain_q : 128'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               chain_q <= '0;
    else if (fsm == LAST && !err_q)           chain_q <= final_blk;
    else if (fsm == IDLE && !pop && iv_load)  chain_q <= iv;
  end
`else
  assign round0_in = head.block;
`endif

  always_comb begin
    key_round = '0;
    key_len   = kl_q;
    case (fsm)
      IDLE:    if (pop) key_len = head_kl;
      ROUND:   key_round = rnd;
      LAST:    key_round = nr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      st        <= '0;
      rnd       <= '0;
      kl_q      <= '0;
      id_q      <= '0;
      err_q     <= 1'b0;
      out_valid <= 1'b0;
      out_block <= '0;
      out_id    <= '0;
      out_err   <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (pop) begin
          st    <= round0_in ^ round_key;
          kl_q  <= head_kl;
          id_q  <= head.id;
          err_q <= (head.keylen == 2'b11);
          rnd   <= 4'd1;
          fsm   <= ROUND;
        end
        ROUND: begin
          st  <= mix_state ^ round_key;
          rnd <= rnd + 4'd1;
          if (rnd == nr - 4'd1) fsm <= LAST;
        end
        LAST: begin
          out_block <= final_blk;
          out_valid <= 1'b1;
          out_id    <= id_q;
          out_err   <= err_q;
          fsm       <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          fsm       <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_encipher_stream.sv
// Bench for aes_encipher_stream: key-schedule store model, vector table, scoreboard,
// backpressure / reset / CBC sequences against published AES vectors.

module tb_aes_encipher_stream;
  localparam int ID_W = 4;

  localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT_F   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic            clk = 1'b0, rst_n = 1'b1;
  logic            in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err, busy;
  logic [127:0]    in_block = '0, round_key, out_block;
  logic [1:0]      in_keylen = '0, key_len;
  logic [ID_W-1:0] in_id = '0, out_id;
  logic [3:0]      key_round;
`ifdef AES_CBC_EN
  logic            in_chain = 1'b0, iv_load = 1'b0;
  logic [127:0]    iv = '0;
`endif

  aes_encipher_stream #(.IN_FIFO_DEPTH(2), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_keylen(in_keylen), .in_id(in_id),
`ifdef AES_CBC_EN
    .in_chain(in_chain), .iv_load(iv_load), .iv(iv),
`endif
    .key_round(key_round), .key_len(key_len), .round_key(round_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_id(out_id), .out_err(out_err), .busy(busy));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Key-schedule store model
  logic [7:0]   sb [256];
  logic [127:0] rks [4][16];
  assign round_key = rks[key_len][key_round];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse plus affine map
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input int kl, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = 4 + 2 * kl;
    nr = 10 + 2 * kl;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rks[kl][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard
  typedef struct { logic [ID_W-1:0] id; logic [127:0] ct; logic err; } exp_t;
  exp_t sbq [$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out: id %0d block %h", out_id, out_block);
      end else begin
        mon_e = sbq.pop_front();
        check("out_block", out_block, mon_e.ct);
        check("out_id", 128'(out_id), 128'(mon_e.id));
        check("out_err", 128'(out_err), 128'(mon_e.err));
      end
    end
  end

  task automatic push(input logic [1:0] kl, input logic [ID_W-1:0] id, input logic [127:0] pt,
                      input logic chain, input logic [127:0] ct, input logic err);
    int g;
    g = 0;
    @(negedge clk);
    in_valid = 1'b1; in_keylen = kl; in_id = id; in_block = pt;
`ifdef AES_CBC_EN
    in_chain = chain;
`else
    if (chain) in_block = pt;
`endif
    while (!in_ready && g < 200) begin @(negedge clk); g++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL push_timeout: id %0d got in_ready 0 want 1", id);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sbq.push_back('{id, ct, err});
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((sbq.size() != 0 || busy) && g < 500) begin @(negedge clk); g++; end
    if (g >= 500) begin
      tests++; fails++;
      $display("FAIL drain_timeout: pending %0d want 0", sbq.size());
    end
  endtask

  typedef struct {
    logic [1:0] kl; logic [ID_W-1:0] id; logic [255:0] key;
    logic [127:0] pt; logic [127:0] ct; logic err;
  } vec_t;
  vec_t vecs [6];

  initial begin #500000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  int eff, lat, g;

  initial begin
    vecs[0] = '{2'd0, 4'd1, KEY_A, PT_F, CT128, 1'b0};
    vecs[1] = '{2'd1, 4'd2, KEY_A, PT_F, CT192, 1'b0};
    vecs[2] = '{2'd2, 4'd3, KEY_A, PT_F, CT256, 1'b0};
    vecs[3] = '{2'd3, 4'd7, KEY_A, PT_F, CT128, 1'b1};
    vecs[4] = '{2'd0, 4'd5, KEY_B, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32, 1'b0};
    vecs[5] = '{2'd0, 4'd6, KEY_B, 128'h6bc1bee22e409f96e93d7e117393172a,
                128'h3ad77bb40d7a3660a89ecaf32466ef97, 1'b0};
    for (int x = 0; x < 256; x++) sb[x] = sbox_calc(8'(x));
    for (int k = 0; k < 4; k++) for (int r = 0; r < 16; r++) rks[k][r] = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #10;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_block", out_block, 128'd0);
    check("rst_out_id", 128'(out_id), 128'd0);
    check("rst_out_err", 128'(out_err), 128'd0);
    check("rst_key_round", 128'(key_round), 128'd0);
    check("rst_key_len", 128'(key_len), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    @(negedge clk); rst_n = 1'b1;

    // Vector table: ciphertext, tag, err, key index and latency
    for (int v = 0; v < 6; v++) begin
      eff = (vecs[v].kl == 2'd3) ? 0 : int'(vecs[v].kl);
      lat = 0;
      expand(eff, vecs[v].key);
      out_ready = 1'b1;
      push(vecs[v].kl, vecs[v].id, vecs[v].pt, 1'b0, vecs[v].ct, vecs[v].err);
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk); #1;
        if (c == 2) begin
          check("key_len", 128'(key_len), 128'(eff));
          check("key_round", 128'(key_round), 128'd2);
        end
        if (out_valid) begin lat = c; break; end
      end
      check("latency", 128'(lat), 128'(11 + 2 * eff));
      wait_drain();
    end

    // Backpressure: FIFO fills, first result held, then in-order release
    expand(0, KEY_A); expand(1, KEY_A); expand(2, KEY_A);
    out_ready = 1'b0;
    push(2'd0, 4'd1, PT_F, 1'b0, CT128, 1'b0);
    push(2'd1, 4'd2, PT_F, 1'b0, CT192, 1'b0);
    push(2'd2, 4'd3, PT_F, 1'b0, CT256, 1'b0);
    @(negedge clk);
    check("in_ready_full", 128'(in_ready), 128'd0);
    g = 0;
    while (!out_valid && g < 40) begin @(negedge clk); g++; end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold_valid", 128'(out_valid), 128'd1);
      check("hold_id", 128'(out_id), 128'd1);
      check("hold_block", out_block, CT128);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    push(2'd0, 4'd4, PT_F, 1'b0, CT128, 1'b0);
    wait_drain();

    // Reset during round 5 with a second request queued
    push(2'd1, 4'd9, PT_F, 1'b0, CT192, 1'b0);
    push(2'd1, 4'd10, PT_F, 1'b0, CT192, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_key_round", 128'(key_round), 128'd5);
    rst_n = 1'b0;
    sbq.delete();
    #1;
    check("mrst_out_valid", 128'(out_valid), 128'd0);
    check("mrst_out_block", out_block, 128'd0);
    check("mrst_out_id", 128'(out_id), 128'd0);
    check("mrst_key_len", 128'(key_len), 128'd0);
    check("mrst_key_round", 128'(key_round), 128'd0);
    check("mrst_busy", 128'(busy), 128'd0);
    check("mrst_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mrst_no_stale", 128'(out_valid), 128'd0);
    check("mrst_idle", 128'(busy), 128'd0);
    push(2'd1, 4'd11, PT_F, 1'b0, CT192, 1'b0);
    wait_drain();

`ifdef AES_CBC_EN
    // CBC-AES128 from SP800-38A
    expand(0, KEY_B);
    @(negedge clk); iv_load = 1'b1; iv = 128'h000102030405060708090a0b0c0d0e0f;
    @(posedge clk); #1 iv_load = 1'b0;
    push(2'd0, 4'd12, 128'h6bc1bee22e409f96e93d7e117393172a, 1'b1,
         128'h7649abac8119b246cee98e9b12e9197d, 1'b0);
    push(2'd0, 4'd13, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1,
         128'h5086cb9b507219ee95db113a917678b2, 1'b0);
    wait_drain();
    in_chain = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
